// File: rtl/hash_engine_job_arbiter.sv
// Shares one hash engine between NUM_PORTS streams: per-job round-robin grant on the input
// side, tag FIFO steering in-order results back. Optional HASH_ARB_STATS_EN adds per-port job counters.
module hash_engine_job_arbiter #(
    parameter int NUM_PORTS      = 2,
    parameter int DATA_WIDTH     = 256,
    parameter int TAG_FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            req_valid,
    output logic [NUM_PORTS-1:0]            req_ready,
    input  logic [NUM_PORTS-1:0]            req_delim,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_data,
    output logic                            eng_in_valid,
    input  logic                            eng_in_ready,
    output logic                            eng_in_delim,
    output logic [DATA_WIDTH-1:0]           eng_in_data,
    input  logic                            eng_out_valid,
    input  logic                            eng_out_delim,
    output logic                            eng_out_ready,
    output logic [NUM_PORTS-1:0]            rsp_valid,
    input  logic [NUM_PORTS-1:0]            rsp_ready,
    output logic                            rsp_delim,
    output logic                            busy,
    output logic                            err_orphan
`ifdef HASH_ARB_STATS_EN
    ,
    output logic [NUM_PORTS*16-1:0]         stat_job_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_PORTS);
    localparam int SEL_W = IDX_W + 1;
    localparam int PTR_W = $clog2(TAG_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     tag_mem_q [TAG_FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic                 err_orphan_q;

    logic                 fifo_empty_s, fifo_full_s;
    logic                 grant_found_s, grant_en_s, in_last_s, push_s, pop_s;
    logic [IDX_W-1:0]     grant_idx_s, head_tag_s, owner_inc_s;
    logic [SEL_W-1:0]     cand_s;
    logic [DATA_WIDTH-1:0] sel_data_s;

    assign fifo_empty_s = (count_q == {CNT_W{1'b0}});
    assign fifo_full_s  = (count_q >= CNT_W'(TAG_FIFO_DEPTH));
    assign head_tag_s   = tag_mem_q[rd_ptr_q];
    assign owner_inc_s  = (owner_q == IDX_W'(NUM_PORTS - 1)) ? {IDX_W{1'b0}} : owner_q + IDX_W'(1);
    assign grant_en_s   = (state_q == ST_IDLE) && grant_found_s && !fifo_full_s;
    assign in_last_s    = (state_q == ST_LOCKED) && req_valid[owner_q] && req_delim[owner_q] && eng_in_ready;
    assign push_s       = grant_en_s;
    assign pop_s        = eng_out_valid && eng_out_ready && eng_out_delim;

    // Round-robin search: first valid port at or above rr_ptr, wrapping at NUM_PORTS
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = {IDX_W{1'b0}};
        cand_s        = {SEL_W{1'b0}};
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand_s = {1'b0, rr_ptr_q} + SEL_W'(i);
            cand_s = (cand_s >= SEL_W'(NUM_PORTS)) ? cand_s - SEL_W'(NUM_PORTS) : cand_s;
            if (!grant_found_s && req_valid[cand_s[IDX_W-1:0]]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_s[IDX_W-1:0];
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Owner data mux
    always_comb begin
        sel_data_s = {DATA_WIDTH{1'b0}};
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (owner_q == IDX_W'(p)) begin
                sel_data_s = req_data[p*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_en_s) begin
                    state_d = ST_LOCKED;
                    owner_d = grant_idx_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (in_last_s) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = owner_inc_s;
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic; the empty check keeps an orphaned result stalled at the engine
    always_comb begin
        req_ready    = {NUM_PORTS{1'b0}};
        eng_in_valid = 1'b0;
        eng_in_delim = req_delim[owner_q];
        eng_in_data  = sel_data_s;
        if (state_q == ST_LOCKED) begin
            eng_in_valid       = req_valid[owner_q];
            req_ready[owner_q] = eng_in_ready;
        end else begin
            eng_in_valid = 1'b0;
        end
        rsp_valid             = {NUM_PORTS{1'b0}};
        rsp_valid[head_tag_s] = eng_out_valid && !fifo_empty_s;
        eng_out_ready         = rsp_ready[head_tag_s] && !fifo_empty_s;
        rsp_delim             = eng_out_delim;
        busy                  = (state_q != ST_IDLE) || !fifo_empty_s;
        err_orphan            = err_orphan_q;
    end

    // State, tag FIFO and sticky error registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= {IDX_W{1'b0}};
            rr_ptr_q     <= {IDX_W{1'b0}};
            wr_ptr_q     <= {PTR_W{1'b0}};
            rd_ptr_q     <= {PTR_W{1'b0}};
            count_q      <= {CNT_W{1'b0}};
            err_orphan_q <= 1'b0;
            for (int k = 0; k < TAG_FIFO_DEPTH; k++) begin
                tag_mem_q[k] <= {IDX_W{1'b0}};
            end
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            if (push_s) begin
                tag_mem_q[wr_ptr_q] <= grant_idx_s;
                wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (eng_out_valid && fifo_empty_s) begin
                err_orphan_q <= 1'b1;
            end
        end
    end

`ifdef HASH_ARB_STATS_EN
    logic [15:0] stat_q [NUM_PORTS];

    // Saturating per-port completed-job counters, bumped on each tag pop
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                stat_q[p] <= 16'h0000;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (pop_s && (head_tag_s == IDX_W'(p)) && (stat_q[p] != 16'hFFFF)) begin
                    stat_q[p] <= stat_q[p] + 16'h0001;
                end
            end
        end
    end

    // Flatten counters onto the status port
    always_comb begin
        stat_job_cnt = {(NUM_PORTS*16){1'b0}};
        for (int p = 0; p < NUM_PORTS; p++) begin
            stat_job_cnt[p*16 +: 16] = stat_q[p];
        end
    end
`else
    // Job counters absent in this build.
`endif

endmodule

// File: tb/tb_hash_engine_job_arbiter.sv
// Directed bench for hash_engine_job_arbiter (NUM_PORTS=2, DATA_WIDTH=256, TAG_FIFO_DEPTH=4).
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_hash_engine_job_arbiter;
    localparam int NP = 2;
    localparam int DW = 256;
    localparam logic [DW-1:0] D0 = {8{32'hD0D0_1234}};
    localparam logic [DW-1:0] D1 = {8{32'hD1D1_5678}};
    localparam logic [DW-1:0] A1 = {8{32'hA1A1_0001}};
    localparam logic [DW-1:0] A2 = {8{32'hA2A2_0002}};
    localparam logic [DW-1:0] A3 = {8{32'hA3A3_0003}};

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NP-1:0]    req_valid, req_ready, req_delim;
    logic [NP*DW-1:0] req_data;
    logic             eng_in_valid, eng_in_ready, eng_in_delim;
    logic [DW-1:0]    eng_in_data;
    logic             eng_out_valid, eng_out_delim, eng_out_ready;
    logic [NP-1:0]    rsp_valid, rsp_ready;
    logic             rsp_delim, busy, err_orphan;
`ifdef HASH_ARB_STATS_EN
    logic [NP*16-1:0] stat_job_cnt;
`endif

    int checks = 0;
    int failures = 0;

    hash_engine_job_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .TAG_FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_delim(req_delim), .req_data(req_data),
        .eng_in_valid(eng_in_valid), .eng_in_ready(eng_in_ready), .eng_in_delim(eng_in_delim),
        .eng_in_data(eng_in_data),
        .eng_out_valid(eng_out_valid), .eng_out_delim(eng_out_delim), .eng_out_ready(eng_out_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_delim(rsp_delim),
        .busy(busy), .err_orphan(err_orphan)
`ifdef HASH_ARB_STATS_EN
        , .stat_job_cnt(stat_job_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid = 2'b00; req_delim = 2'b00; req_data = {(NP*DW){1'b0}};
        eng_in_ready = 1'b0; eng_out_valid = 1'b0; eng_out_delim = 1'b0; rsp_ready = 2'b00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick(); tick();
        #1;
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
        checks++; if (eng_in_valid !== 1'b0) begin failures++; $display("FAIL reset_eng_in_valid got=%b exp=0", eng_in_valid); end
        checks++; if (eng_out_ready !== 1'b0) begin failures++; $display("FAIL reset_eng_out_ready got=%b exp=0", eng_out_ready); end
        checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (err_orphan !== 1'b0) begin failures++; $display("FAIL reset_err_orphan got=%b exp=0", err_orphan); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_job();
        do_reset();
        req_valid = 2'b01; req_delim = 2'b00; req_data[0 +: DW] = A1; eng_in_ready = 1'b1;
        #1;
        checks++; if (eng_in_valid !== 1'b0) begin failures++; $display("FAIL single_idle_valid got=%b exp=0", eng_in_valid); end
        tick();
        #1;
        checks++; if (eng_in_valid !== 1'b1) begin failures++; $display("FAIL single_grant_valid got=%b exp=1", eng_in_valid); end
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL single_req_ready got=%b exp=01", req_ready); end
        checks++; if (eng_in_data !== A1) begin failures++; $display("FAIL single_beat1_data got=%h exp=%h", eng_in_data, A1); end
        tick();
        req_data[0 +: DW] = A2;
        #1;
        checks++; if (eng_in_data !== A2) begin failures++; $display("FAIL single_beat2_data got=%h exp=%h", eng_in_data, A2); end
        checks++; if (eng_in_delim !== 1'b0) begin failures++; $display("FAIL single_beat2_delim got=%b exp=0", eng_in_delim); end
        tick();
        req_data[0 +: DW] = A3; req_delim = 2'b01;
        #1;
        checks++; if (eng_in_delim !== 1'b1) begin failures++; $display("FAIL single_beat3_delim got=%b exp=1", eng_in_delim); end
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL single_beat3_ready got=%b exp=01", req_ready); end
        tick();
        req_valid = 2'b00; req_delim = 2'b00;
        #1;
        checks++; if (eng_in_valid !== 1'b0) begin failures++; $display("FAIL single_back_idle got=%b exp=0", eng_in_valid); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_inflight got=%b exp=1", busy); end
        eng_out_valid = 1'b1; eng_out_delim = 1'b1; rsp_ready = 2'b01;
        #1;
        checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL single_rsp_valid got=%b exp=01", rsp_valid); end
        checks++; if (eng_out_ready !== 1'b1) begin failures++; $display("FAIL single_eng_out_ready got=%b exp=1", eng_out_ready); end
        checks++; if (rsp_delim !== 1'b1) begin failures++; $display("FAIL single_rsp_delim got=%b exp=1", rsp_delim); end
        tick();
        eng_out_valid = 1'b0; eng_out_delim = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_drained got=%b exp=0", busy); end
        checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL single_rsp_after_pop got=%b exp=00", rsp_valid); end
    endtask

    // Leaves four tags (0,1,0,1) queued and the arbiter idle; test_full_fifo relies on it.
    task automatic test_round_robin();
        logic [NP-1:0] exp_rdy;
        logic [DW-1:0] exp_data;
        do_reset();
        req_valid = 2'b11; req_delim = 2'b11; eng_in_ready = 1'b1;
        req_data[0 +: DW] = D0; req_data[DW +: DW] = D1;
        for (int j = 0; j < 4; j++) begin
            exp_rdy  = (j % 2 == 0) ? 2'b01 : 2'b10;
            exp_data = (j % 2 == 0) ? D0 : D1;
            #1;
            checks++; if (eng_in_valid !== 1'b0) begin failures++; $display("FAIL rr_idle_bubble job=%0d got=%b exp=0", j, eng_in_valid); end
            tick();
            #1;
            checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL rr_grant job=%0d got=%b exp=%b", j, req_ready, exp_rdy); end
            checks++; if (eng_in_data !== exp_data) begin failures++; $display("FAIL rr_data job=%0d got=%h exp=%h", j, eng_in_data, exp_data); end
            tick();
        end
        req_valid = 2'b00; req_delim = 2'b00;
    endtask

    task automatic test_full_fifo();
        req_valid = 2'b01; req_delim = 2'b01;
        for (int j = 0; j < 2; j++) begin
            #1;
            checks++; if (eng_in_valid !== 1'b0) begin failures++; $display("FAIL full_no_grant_valid cyc=%0d got=%b exp=0", j, eng_in_valid); end
            checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL full_no_grant_ready cyc=%0d got=%b exp=00", j, req_ready); end
            tick();
        end
        eng_out_valid = 1'b1; eng_out_delim = 1'b1; rsp_ready = 2'b11;
        #1;
        checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL full_head_tag got=%b exp=01", rsp_valid); end
        checks++; if (eng_out_ready !== 1'b1) begin failures++; $display("FAIL full_pop_ready got=%b exp=1", eng_out_ready); end
        tick();
        eng_out_valid = 1'b0; eng_out_delim = 1'b0;
        #1;
        checks++; if (eng_in_valid !== 1'b0) begin failures++; $display("FAIL full_no_bypass got=%b exp=0", eng_in_valid); end
        tick();
        #1;
        checks++; if (eng_in_valid !== 1'b1) begin failures++; $display("FAIL full_grant_after_pop got=%b exp=1", eng_in_valid); end
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL full_grant_owner got=%b exp=01", req_ready); end
        tick();
        req_valid = 2'b00; req_delim = 2'b00; rsp_ready = 2'b00;
    endtask

    task automatic test_out_of_order();
        do_reset();
        eng_in_ready = 1'b1; req_delim = 2'b11;
        req_valid = 2'b10;
        tick();
        #1;
        checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL ooo_grant_p1 got=%b exp=10", req_ready); end
        tick();
        req_valid = 2'b01;
        tick();
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL ooo_grant_p0 got=%b exp=01", req_ready); end
        tick();
        req_valid = 2'b00; req_delim = 2'b00;
        eng_out_valid = 1'b1; eng_out_delim = 1'b1; rsp_ready = 2'b01;
        for (int j = 0; j < 2; j++) begin
            #1;
            checks++; if (eng_out_ready !== 1'b0) begin failures++; $display("FAIL ooo_stall cyc=%0d got=%b exp=0", j, eng_out_ready); end
            checks++; if (rsp_valid !== 2'b10) begin failures++; $display("FAIL ooo_stall_rsp cyc=%0d got=%b exp=10", j, rsp_valid); end
            tick();
        end
        rsp_ready = 2'b11; eng_out_delim = 1'b0;
        #1;
        checks++; if (eng_out_ready !== 1'b1) begin failures++; $display("FAIL ooo_release got=%b exp=1", eng_out_ready); end
        tick();
        eng_out_delim = 1'b1;
        #1;
        checks++; if (rsp_valid !== 2'b10) begin failures++; $display("FAIL ooo_no_pop_midjob got=%b exp=10", rsp_valid); end
        tick();
        #1;
        checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL ooo_second_tag got=%b exp=01", rsp_valid); end
        checks++; if (eng_out_ready !== 1'b1) begin failures++; $display("FAIL ooo_second_ready got=%b exp=1", eng_out_ready); end
        tick();
        eng_out_valid = 1'b0; eng_out_delim = 1'b0; rsp_ready = 2'b00;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ooo_drained_busy got=%b exp=0", busy); end
        checks++; if (err_orphan !== 1'b0) begin failures++; $display("FAIL ooo_no_orphan got=%b exp=0", err_orphan); end
    endtask

    task automatic test_orphan_and_reset();
        do_reset();
        eng_out_valid = 1'b1; eng_out_delim = 1'b1; rsp_ready = 2'b11;
        #1;
        checks++; if (eng_out_ready !== 1'b0) begin failures++; $display("FAIL orphan_stall got=%b exp=0", eng_out_ready); end
        checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL orphan_rsp_valid got=%b exp=00", rsp_valid); end
        tick();
        eng_out_valid = 1'b0;
        #1;
        checks++; if (err_orphan !== 1'b1) begin failures++; $display("FAIL orphan_latched got=%b exp=1", err_orphan); end
        req_valid = 2'b01; req_delim = 2'b01; eng_in_ready = 1'b1; rsp_ready = 2'b01;
        tick();
        #1;
        checks++; if (eng_in_valid !== 1'b1) begin failures++; $display("FAIL orphan_traffic_grant got=%b exp=1", eng_in_valid); end
        tick();
        req_valid = 2'b00; req_delim = 2'b00;
        eng_out_valid = 1'b1;
        #1;
        checks++; if (eng_out_ready !== 1'b1) begin failures++; $display("FAIL orphan_traffic_pop got=%b exp=1", eng_out_ready); end
        tick();
        eng_out_valid = 1'b0;
        #1;
        checks++; if (err_orphan !== 1'b1) begin failures++; $display("FAIL orphan_sticky got=%b exp=1", err_orphan); end
        req_valid = 2'b01; req_delim = 2'b00;
        tick();
        #1;
        checks++; if (eng_in_valid !== 1'b1) begin failures++; $display("FAIL midlock_locked got=%b exp=1", eng_in_valid); end
        rst_n = 1'b0;
        tick();
        #1;
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL midlock_rst_ready got=%b exp=00", req_ready); end
        checks++; if (eng_in_valid !== 1'b0) begin failures++; $display("FAIL midlock_rst_valid got=%b exp=0", eng_in_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midlock_rst_busy got=%b exp=0", busy); end
        checks++; if (err_orphan !== 1'b0) begin failures++; $display("FAIL midlock_rst_orphan got=%b exp=0", err_orphan); end
        checks++; if (eng_out_ready !== 1'b0) begin failures++; $display("FAIL midlock_rst_out_ready got=%b exp=0", eng_out_ready); end
        checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL midlock_rst_rsp got=%b exp=00", rsp_valid); end
        rst_n = 1'b1;
        clear_inputs();
        tick();
    endtask

`ifdef HASH_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        eng_in_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_valid = 2'b10; req_delim = 2'b10;
            tick(); tick();
        end
        req_valid = 2'b00; req_delim = 2'b00;
        eng_out_valid = 1'b1; eng_out_delim = 1'b1; rsp_ready = 2'b10;
        tick(); tick(); tick();
        eng_out_valid = 1'b0; eng_out_delim = 1'b0;
        #1;
        checks++; if (stat_job_cnt[31:16] !== 16'd3) begin failures++; $display("FAIL stats_port1 got=%0d exp=3", stat_job_cnt[31:16]); end
        checks++; if (stat_job_cnt[15:0] !== 16'd0) begin failures++; $display("FAIL stats_port0 got=%0d exp=0", stat_job_cnt[15:0]); end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_single_job();
        test_round_robin();
        test_full_fifo();
        test_out_of_order();
        test_orphan_and_reset();
`ifdef HASH_ARB_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hash_engine_job_arbiter.md
# hash_engine_job_arbiter

Shares one `hash_engine_top` instance between `NUM_PORTS` independent compression streams. Grants the engine input to one stream per job, holding the grant until the beat carrying `delim` completes. Records the grant order in a tag FIFO so that in-order engine results return to the requester that issued them. Sits between the per-stream input framers and the hash engine input, and between the engine output and the per-stream match stages.

## Interface
- `NUM_PORTS`, default 2: requester count, legal range 2..8; `IDX_W = $clog2(NUM_PORTS)`.
- `DATA_WIDTH`, default 256: input beat width; equals `HASH_ISSUE_WIDTH*8`.
- `TAG_FIFO_DEPTH`, default 4: maximum number of jobs in flight inside the engine; power of two, at least 2.

Ports:
- `clk` in 1: clock; single clock domain.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in `NUM_PORTS`: per-port input beat valid.
- `req_ready` out `NUM_PORTS`: per-port input beat ready.
- `req_delim` in `NUM_PORTS`: per-port end-of-job marker.
- `req_data` in `NUM_PORTS*DATA_WIDTH`: port p occupies `[p*DATA_WIDTH +: DATA_WIDTH]`.
- `eng_in_valid` / `eng_in_ready` / `eng_in_delim` out/in/out 1: to engine `input_*`.
- `eng_in_data` out `DATA_WIDTH`: to engine `input_data`.
- `eng_out_valid` in 1, `eng_out_delim` in 1, `eng_out_ready` out 1: from/to engine output handshake. Payload fields bypass this block and are broadcast to all ports.
- `rsp_valid` out `NUM_PORTS`, `rsp_ready` in `NUM_PORTS`: per-port result handshake.
- `rsp_delim` out 1: copy of `eng_out_delim`.
- `busy` out 1: high when the FSM is not in IDLE or the tag FIFO is non-empty.
- `err_orphan` out 1: sticky; set when `eng_out_valid` is high while the tag FIFO is empty.

## Operation
FSM states are IDLE and LOCKED. Registers: `owner[IDX_W]`, `rr_ptr[IDX_W]`, tag FIFO of `IDX_W`-bit entries with a `$clog2(TAG_FIFO_DEPTH)+1`-bit count.

**IDLE**
- All `req_ready` = 0; `eng_in_valid` = 0.
- If any `req_valid` is high and FIFO count < `TAG_FIFO_DEPTH`, select the first valid port searching upward from `rr_ptr`, modulo `NUM_PORTS`.
- On that selection: `owner` <= port, push port into the FIFO, move to LOCKED.
- No grant while the FIFO is full. The full check uses the pre-pop count; there is no same-cycle bypass.

**LOCKED**
- `eng_in_valid = req_valid[owner]`; `eng_in_data` and `eng_in_delim` are taken from `owner`.
- `req_ready[owner] = eng_in_ready`; all other `req_ready` = 0.
- On a handshake with `delim` = 1: `rr_ptr` <= `owner+1`, wrapping at `NUM_PORTS` (not at 2^`IDX_W`), and return to IDLE.

**Return path**
- Head tag `h`.
- `rsp_valid[h] = eng_out_valid & !empty`; other `rsp_valid` = 0.
- `eng_out_ready = rsp_ready[h] & !empty`.
- Pop the FIFO on an output handshake with `eng_out_delim` = 1.
- Push and pop in the same cycle leave the count unchanged.

**Errors**
- Empty FIFO with `eng_out_valid` high: `eng_out_ready` = 0 (engine stalls) and `err_orphan` <= 1. It clears only on reset.

## Timing
- Reset (`rst_n` = 0 at a clock edge) sets: FSM = IDLE, `owner` = 0, `rr_ptr` = 0, FIFO empty, `err_orphan` = 0.
- Resulting output values: all `req_ready` = 0, `eng_in_valid` = 0, `eng_out_ready` = 0, `rsp_valid` = 0, `busy` = 0.
- Reset mid-job discards the lock and all in-flight tags. The engine must be reset in the same cycle.
- Grant latency: one cycle. A request seen in IDLE in cycle N is presented to the engine in cycle N+1.
- Each job costs exactly one IDLE bubble cycle between jobs.
- Data path: input side is combinational muxing, zero added latency. Return side is combinational from the FIFO head, zero added latency.
- `req_valid` must stay high, with stable `req_data` and `req_delim`, until `req_ready`, following the engine valid/ready rules.
- A one-beat job (`delim` on its first beat) is legal: IDLE to LOCKED to IDLE, two cycles minimum.

## Configuration
- `HASH_ARB_STATS_EN` defined: adds output `stat_job_cnt` (`NUM_PORTS*16`), one 16-bit counter per port.
  - Counter increments on each pop whose tag is that port.
  - Counter saturates at 16'hFFFF.
  - Counter resets to 0.
- Not defined: the port and counters are absent; all other behaviour is identical.

## Test plan
- Single port: port 0 sends a 3-beat job with `eng_in_ready` = 1 -> grant in cycle 1, beats in cycles 1-3, IDLE in cycle 4, FIFO holds tag 0. Engine output with delim -> `rsp_valid[0]` = 1, FIFO empties, `busy` falls.
- Round-robin: ports 0 and 1 both request continuously with 1-beat jobs -> grant sequence 0,1,0,1. `rr_ptr` wraps from 1 to 0 with `NUM_PORTS` = 2.
- Full FIFO: 4 jobs issued, engine output held with `eng_out_valid` = 0 -> fifth request is not granted. One output pop -> grant on the following cycle.
- Out-of-order readiness: tags 1,0 queued, `rsp_ready[0]` = 1, `rsp_ready[1]` = 0 -> `eng_out_ready` = 0 until `rsp_ready[1]` rises. Then port 1 receives its data first.
- Orphan: `eng_out_valid` = 1 with FIFO empty -> `eng_out_ready` = 0 and `err_orphan` latches 1 and holds through later traffic. Reset mid-LOCKED -> all outputs at their reset values the next cycle.
- With `HASH_ARB_STATS_EN`: 3 jobs on port 1 -> `stat_job_cnt[31:16]` = 3 and `stat_job_cnt[15:0]` = 0.
